// File: rtl/apb_pkg.sv
// Shared APB definitions used by the master controller and the APB slave:
// transfer FSM states, default bus geometry and timeout helpers.
package apb_pkg;

   localparam int unsigned APB_ADDR_WIDTH = 32;
   localparam int unsigned APB_DATA_WIDTH = 8;
   localparam int unsigned APB_TIMEOUT    = 16;
   localparam int unsigned APB_CNT_WIDTH  = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } apb_state_e;

   // Count value at which an ACCESS phase with no pready is abandoned.
   function automatic logic [APB_CNT_WIDTH-1:0] timeout_last(input int unsigned t);
      logic [APB_CNT_WIDTH-1:0] v;
      v = t[APB_CNT_WIDTH-1:0] - 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS cycles spent waiting on pready; o_expire flags that the
// current wait cycle is the last one allowed before the transfer is aborted.
module apb_timeout_cnt
   import apb_pkg::*;
#(
   parameter int unsigned TIMEOUT = APB_TIMEOUT
) (
   input  logic pclk,
   input  logic prstn,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [APB_CNT_WIDTH-1:0] LAST = timeout_last(TIMEOUT);

   logic [APB_CNT_WIDTH-1:0] r_count;

   // Saturates at LAST so a stalled enable can never wrap back to zero.
   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LAST)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = (r_count == LAST);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: turns one command at a time into a SETUP/ACCESS transfer and
// returns a response (read data or error/timeout) through a valid/ready port.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH,
   parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH,
   parameter int unsigned TIMEOUT    = APB_TIMEOUT
) (
   input  logic                  pclk,
   input  logic                  prstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [DATA_WIDTH-1:0] pwdata,
   input  logic                  pready,
   input  logic [DATA_WIDTH-1:0] prdata,
   input  logic                  pslverr
);

   apb_state_e            r_state;
   logic                  r_cmd_ready;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [DATA_WIDTH-1:0] r_pwdata;

   logic w_accept;
   logic w_wait;
   logic w_expire;

   // r_cmd_ready is only ever set while in IDLE, so it alone qualifies accept.
   assign w_accept = cmd_valid & r_cmd_ready;
   assign w_wait   = (r_state == ST_ACCESS) & ~pready;

   apb_timeout_cnt #(
      .TIMEOUT (TIMEOUT)
   ) u_timeout (
      .pclk     (pclk),
      .prstn    (prstn),
      .i_clear  (w_accept),
      .i_enable (w_wait),
      .o_expire (w_expire)
   );

   always_ff @(posedge pclk or negedge prstn) begin
      if (!prstn) begin
         r_state     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_paddr     <= '0;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_pwdata    <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (w_accept) begin
                  r_cmd_ready <= 1'b0;
                  r_paddr     <= cmd_addr;
                  r_pwrite    <= cmd_write;
                  r_pwdata    <= cmd_wdata;
                  r_psel      <= 1'b1;
                  r_state     <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               // pready is checked first so it wins over a same-cycle timeout.
               if (pready) begin
                  r_rsp_rdata <= r_pwrite ? '0 : prdata;
                  r_rsp_err   <= pslverr;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_RESP;
               end else if (w_expire) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign cmd_ready = r_cmd_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign paddr     = r_paddr;
   assign psel      = r_psel;
   assign penable   = r_penable;
   assign pwrite    = r_pwrite;
   assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: each task drives one scenario and
// compares DUT outputs against hand-computed expectations.
module tb_apb_master_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 8;

   logic          pclk;
   logic          prstn;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          rsp_err;
   logic [AW-1:0] paddr;
   logic          psel;
   logic          penable;
   logic          pwrite;
   logic [DW-1:0] pwdata;
   logic          pready;
   logic [DW-1:0] prdata;
   logic          pslverr;

   int vecs = 0;
   int errs = 0;

   apb_master_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .TIMEOUT    (16)
   ) dut (
      .pclk      (pclk),
      .prstn     (prstn),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_write (cmd_write),
      .cmd_addr  (cmd_addr),
      .cmd_wdata (cmd_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pready    (pready),
      .prdata    (prdata),
      .pslverr   (pslverr)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got=running exp=done");
      $fatal(1);
   end

   task automatic tick;
      @(posedge pclk);
      #1;
   endtask

   // Slave values that must be ignored because the bus is not in ACCESS.
   task automatic slave_junk;
      pready  = 1'b1;
      prdata  = 8'hFF;
      pslverr = 1'b1;
   endtask

   task automatic release_rsp;
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   // Issues one command and plays the slave: 'waits' ACCESS cycles with
   // pready low, then completes with rd/er; waits<0 never completes.
   task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input int waits, input logic [DW-1:0] rd, input logic er,
                          output int lat, output int n_psel, output int n_pen,
                          output bit stable);
      int acc;
      bit done;
      cmd_valid = 1'b1;
      cmd_write = w;
      cmd_addr  = a;
      cmd_wdata = d;
      slave_junk();
      acc = 0; lat = 0; n_psel = 0; n_pen = 0; stable = 1'b1; done = 1'b0;
      for (int i = 0; i < 64 && !done; i++) begin
         tick();
         lat++;
         cmd_valid = 1'b0;
         cmd_write = ~w;
         cmd_addr  = ~a;
         cmd_wdata = ~d;
         if (rsp_valid) begin
            done = 1'b1;
         end else begin
            if (psel) n_psel++;
            if (penable) n_pen++;
            if (paddr !== a || pwrite !== w || pwdata !== d) stable = 1'b0;
            if (psel && penable) begin
               acc++;
               if (waits >= 0 && acc > waits) begin
                  pready = 1'b1; prdata = rd; pslverr = er;
               end else begin
                  pready = 1'b0; prdata = 8'h5A; pslverr = 1'b1;
               end
            end else begin
               slave_junk();
            end
         end
      end
      if (!done) lat = -1;
   endtask

   task automatic test_reset;
      prstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 1'b0; slave_junk();
      #3;
      vecs++;
      if ({psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err} !== 6'b0 ||
          paddr !== '0 || pwdata !== '0 || rsp_rdata !== '0) begin
         errs++;
         $display("FAIL reset_outputs got=%b/%h/%h/%h exp=0/0/0/0",
                  {psel, penable, pwrite, cmd_ready, rsp_valid, rsp_err}, paddr, pwdata, rsp_rdata);
      end
      tick();
      tick();
      prstn = 1'b1;
      tick();
      vecs++;
      if (cmd_ready !== 1'b1) begin
         errs++; $display("FAIL reset_release_cmd_ready got=%b exp=1", cmd_ready);
      end
   endtask

   task automatic test_write;
      int lat, np, ne; bit st;
      run_cmd(1'b1, 32'h10, 8'hA5, 0, 8'hEE, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 3) begin errs++; $display("FAIL write_latency got=%0d exp=3", lat); end
      vecs++; if (np !== 2 || ne !== 1) begin
         errs++; $display("FAIL write_psel_penable got=%0d/%0d exp=2/1", np, ne);
      end
      vecs++; if (!st) begin errs++; $display("FAIL write_bus_stable got=0 exp=1"); end
      vecs++; if ({rsp_err, rsp_rdata, psel, penable} !== {1'b0, 8'h00, 2'b00}) begin
         errs++; $display("FAIL write_rsp got=%b/%h/%b%b exp=0/00/00", rsp_err, rsp_rdata, psel, penable);
      end
      release_rsp();
      vecs++; if ({rsp_valid, cmd_ready} !== 2'b01) begin
         errs++; $display("FAIL write_idle got=%b%b exp=01", rsp_valid, cmd_ready);
      end
   endtask

   task automatic test_read_wait;
      int lat, np, ne; bit st;
      run_cmd(1'b0, 32'h20, 8'h00, 3, 8'h3C, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 6 || ne !== 4) begin
         errs++; $display("FAIL read_wait_timing got=%0d/%0d exp=6/4", lat, ne);
      end
      vecs++; if (!st) begin errs++; $display("FAIL read_wait_paddr_stable got=0 exp=1"); end
      vecs++; if ({rsp_err, rsp_rdata} !== {1'b0, 8'h3C}) begin
         errs++; $display("FAIL read_wait_rsp got=%b/%h exp=0/3c", rsp_err, rsp_rdata);
      end
      release_rsp();
   endtask

   task automatic test_timeout;
      int lat, np, ne; bit st;
      run_cmd(1'b0, 32'h24, 8'h00, -1, 8'h00, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 18 || ne !== 16) begin
         errs++; $display("FAIL timeout_access_cycles got=%0d/%0d exp=18/16", lat, ne);
      end
      vecs++; if ({rsp_err, rsp_rdata, psel, penable} !== {1'b1, 8'h00, 2'b00}) begin
         errs++; $display("FAIL timeout_rsp got=%b/%h/%b%b exp=1/00/00", rsp_err, rsp_rdata, psel, penable);
      end
      release_rsp();
   endtask

   task automatic test_pready_wins;
      int lat, np, ne; bit st;
      run_cmd(1'b0, 32'h28, 8'h00, 15, 8'h77, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 18 || ne !== 16) begin
         errs++; $display("FAIL pready_wins_cycles got=%0d/%0d exp=18/16", lat, ne);
      end
      vecs++; if ({rsp_err, rsp_rdata} !== {1'b0, 8'h77}) begin
         errs++; $display("FAIL pready_wins_rsp got=%b/%h exp=0/77", rsp_err, rsp_rdata);
      end
      release_rsp();
   endtask

   task automatic test_slverr_hold;
      int lat, np, ne; bit st;
      run_cmd(1'b1, 32'h44, 8'h99, 0, 8'h12, 1'b1, lat, np, ne, st);
      vecs++; if (lat !== 3 || {rsp_err, rsp_rdata} !== {1'b1, 8'h00}) begin
         errs++; $display("FAIL slverr_rsp got=%0d/%b/%h exp=3/1/00", lat, rsp_err, rsp_rdata);
      end
      cmd_valid = 1'b1; cmd_addr = 32'h88; rsp_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         vecs++;
         if ({rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel} !== {2'b11, 8'h00, 2'b00}) begin
            errs++;
            $display("FAIL slverr_hold_%0d got=%b%b/%h/%b%b exp=11/00/00", i,
                     rsp_valid, rsp_err, rsp_rdata, cmd_ready, psel);
         end
      end
      cmd_valid = 1'b0;
      release_rsp();
      vecs++; if ({rsp_valid, cmd_ready, psel} !== 3'b010) begin
         errs++; $display("FAIL slverr_idle got=%b%b%b exp=010", rsp_valid, cmd_ready, psel);
      end
   endtask

   task automatic test_reset_mid;
      int lat, np, ne; bit st;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30; cmd_wdata = 8'h00;
      slave_junk();
      tick();
      cmd_valid = 1'b0;
      tick();
      pready = 1'b0; prdata = 8'h5A; pslverr = 1'b0;
      tick();
      vecs++; if ({psel, penable} !== 2'b11) begin
         errs++; $display("FAIL reset_mid_in_access got=%b%b exp=11", psel, penable);
      end
      #2 prstn = 1'b0;
      #1;
      vecs++;
      if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000 || paddr !== '0) begin
         errs++; $display("FAIL reset_mid_async got=%b%b%b%b/%h exp=0000/0",
                          psel, penable, rsp_valid, cmd_ready, paddr);
      end
      tick();
      prstn = 1'b1;
      tick();
      vecs++; if ({cmd_ready, rsp_valid, psel} !== 3'b100) begin
         errs++; $display("FAIL reset_mid_release got=%b%b%b exp=100", cmd_ready, rsp_valid, psel);
      end
      run_cmd(1'b0, 32'h34, 8'h00, 1, 8'hC3, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 4 || {rsp_err, rsp_rdata} !== {1'b0, 8'hC3}) begin
         errs++; $display("FAIL reset_mid_next_cmd got=%0d/%b/%h exp=4/0/c3", lat, rsp_err, rsp_rdata);
      end
      release_rsp();
   endtask

   task automatic test_back_to_back;
      int lat, np, ne; bit st;
      run_cmd(1'b1, 32'h50, 8'h11, 0, 8'h00, 1'b0, lat, np, ne, st);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      vecs++; if ({cmd_ready, psel, rsp_valid} !== 3'b100) begin
         errs++; $display("FAIL b2b_idle_gap got=%b%b%b exp=100", cmd_ready, psel, rsp_valid);
      end
      run_cmd(1'b0, 32'h54, 8'h22, 0, 8'h66, 1'b0, lat, np, ne, st);
      vecs++; if (lat !== 3 || !st || rsp_rdata !== 8'h66) begin
         errs++; $display("FAIL b2b_second got=%0d/%0d/%h exp=3/1/66", lat, st, rsp_rdata);
      end
      release_rsp();
   endtask

   initial begin
      test_reset();
      test_write();
      test_read_wait();
      test_timeout();
      test_pready_wins();
      test_slverr_hold();
      test_reset_mid();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
